fifo_drain_serializer: RTL and testbench
========================================

// Module: fifo_drain_serializer
// PURPOSE
//  Read-side consumer for the byte FIFO. Pops bytes when the FIFO is non-empty
//  and serializes each one into a bit stream for the FSM pattern detector.
//  Sits between the FIFO read port (re_en/data_o/empty_o) and the detector's
//  serial input, with a valid/ready handshake toward the detector.
// PARAMETERS
//  DATA_WIDTH  8  width of a FIFO word / bits per serialized word
//  MSB_FIRST   1  1: bit[DATA_WIDTH-1] sent first; 0: bit[0] sent first
// PORTS
//  clk           in   1           single clock, rising edge
//  rst_n         in   1           asynchronous, active-low reset
//  enable_i      in   1           1: allowed to start popping new words
//  empty_i       in   1           FIFO empty flag
//  rd_en_o       out  1           FIFO read enable, single-cycle pulse
//  fifo_data_i   in   DATA_WIDTH  FIFO read data; valid the cycle after rd_en_o
//  bit_o         out  1           serial data bit to detector
//  bit_valid_o   out  1           bit_o holds a valid bit
//  bit_ready_i   in   1           detector accepts bit_o this cycle
//  word_start_o  out  1           high with valid on the first bit of each word
//  busy_o        out  1           state != IDLE
//  word_cnt_o    out  16          count of fully transmitted words, wraps
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; rd_en_o, bit_o, bit_valid_o,
//   word_start_o, busy_o = 0; word_cnt_o = 0; shift reg and bit index = 0.
//  FSM:
//   IDLE  : if enable_i && !empty_i -> REQ, else stay.
//   REQ   : rd_en_o=1 for exactly this cycle -> WAIT.
//   WAIT  : rd_en_o=0; capture fifo_data_i into shift reg at end of cycle;
//           bit index=0 -> SHIFT.
//   SHIFT : bit_valid_o=1; bit_o = current bit per MSB_FIRST; word_start_o=1
//           while index==0. Transfer = bit_valid_o && bit_ready_i: advance
//           index. On transfer with index==DATA_WIDTH-1: word_cnt_o+=1 (mod 2^16)
//           and go REQ if enable_i && !empty_i, else IDLE.
//  Latency: empty_i low in IDLE -> first bit valid 3 cycles later (IDLE,REQ,WAIT).
//   Back-to-back words: 2-cycle bubble (REQ,WAIT) between last and next first bit.
//  Handshake: while bit_valid_o && !bit_ready_i, bit_o and word_start_o hold
//   stable; no bit is skipped or repeated. bit_valid_o never drops mid-word.
//  rd_en_o only asserted in REQ; never two reads outstanding; never asserted
//   while empty_i was high in the deciding cycle (no underflow pop).
//  enable_i low mid-word: current word completes; no further rd_en_o.
//  empty_i rising mid-word: ignored until word end.
//  rst_n low mid-word: all outputs to reset values immediately; partially sent
//   word is dropped (not re-read); next word starts at index 0.
//  Bit index width = $clog2(DATA_WIDTH); compare to DATA_WIDTH-1 at full width.
// STRUCTURE
//  Shared package (fifo_pkg): DATA_WIDTH default, FSM state encodings
//   (IDLE/REQ/WAIT/SHIFT, 2-bit), word counter width (16).
//  One sub-module: piso_shift_reg (load, shift-on-transfer, MSB_FIRST param,
//   bit_o output); FSM, index and word counter stay in the top.
// TESTING
//  1 FIFO holds 0xA5, enable=1, ready=1 -> one rd_en pulse; bits 1,0,1,0,0,1,0,1
//    on 8 consecutive cycles starting 3 cycles after empty_i low; word_start on
//    first bit only; word_cnt_o=1.
//  2 empty_i held 1, enable=1 for 50 cycles -> rd_en_o, bit_valid_o stay 0.
//  3 Word 0x3C, ready=0 for 3 cycles at bit index 4 -> bit_o held at 1,
//    full sequence 0,0,1,1,1,1,0,0 received intact, no duplicates.
//  4 Words 0xFF then 0x00 queued -> exactly 2 rd_en pulses, 2-cycle bubble
//    between streams, word_cnt_o=2.
//  5 rst_n low during bit index 5 -> outputs 0 same cycle; after release with
//    0x81 queued, stream restarts at bit index 0: 1,0,0,0,0,0,0,1.
//  6 MSB_FIRST=0, word 0x01, enable dropped at index 2 -> bits 1,0,0,0,0,0,0,0
//    complete, then IDLE with no further rd_en_o despite non-empty FIFO.

Source files
------------

// File: rtl/fifo_pkg.sv
// ------------------------------------------------------------------
// fifo_pkg: shared widths and FSM encoding for the FIFO drain path
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int WORD_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ------------------------------------------------------------------
// piso_shift_reg: parallel-load shift register, one bit out per shift
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module piso_shift_reg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic                  bit_o
);

  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] sr_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr[DATA_WIDTH-2:0], 1'b0};
      assign bit_o      = sr[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign sr_shifted = {1'b0, sr[DATA_WIDTH-1:1]};
      assign bit_o      = sr[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= sr_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_drain_serializer.sv
// ------------------------------------------------------------------
// fifo_drain_serializer: pops FIFO words and streams them out serially
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_drain_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  empty_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  bit_o,
  output logic                  bit_valid_o,
  input  logic                  bit_ready_i,
  output logic                  word_start_o,
  output logic                  busy_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             sr_bit;
  logic             transfer;
  logic             last_bit;
  logic             can_start;

  assign can_start = enable_i && !empty_i;
  assign transfer  = (state == ST_SHIFT) && bit_ready_i;
  assign last_bit  = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_en_o      = 1'b0;
    bit_valid_o  = 1'b0;
    word_start_o = 1'b0;
    busy_o       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (can_start) state_next = ST_REQ;
      end
      ST_REQ: begin
        rd_en_o    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_valid_o  = 1'b1;
        word_start_o = (idx == '0);
        // Chain straight into the next read so back-to-back words only lose REQ+WAIT
        if (transfer && last_bit) state_next = can_start ? ST_REQ : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gate with valid so the line idles low between words
  assign bit_o = bit_valid_o & sr_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      word_cnt_o <= '0;
    end else begin
      if (state == ST_WAIT) begin
        idx <= '0;
      end else if (transfer) begin
        idx <= last_bit ? '0 : idx + 1'b1;
      end
      if (transfer && last_bit) word_cnt_o <= word_cnt_o + 1'b1;
    end
  end

  piso_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == ST_WAIT),
    .load_data (fifo_data_i),
    .shift     (transfer),
    .bit_o     (sr_bit)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_serializer.sv
// ------------------------------------------------------------------
// tb_fifo_drain_serializer: FIFO model, bit scoreboard and corner sequences
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fifo_drain_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instance A: MSB first
  logic        en_a = 1'b0, rdy_a = 1'b1;
  logic        rd_a, bit_a, val_a, ws_a, busy_a, empty_a;
  logic [15:0] cnt_a;
  logic [7:0]  data_a = '0;
  logic [7:0]  mem_a [64];
  int          wp_a = 0, rp_a = 0;

  assign empty_a = (wp_a == rp_a);
  always @(posedge clk) if (rd_a) begin
    data_a <= mem_a[rp_a % 64];
    rp_a   <= rp_a + 1;
  end

  fifo_drain_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable_i(en_a), .empty_i(empty_a), .rd_en_o(rd_a),
    .fifo_data_i(data_a), .bit_o(bit_a), .bit_valid_o(val_a), .bit_ready_i(rdy_a),
    .word_start_o(ws_a), .busy_o(busy_a), .word_cnt_o(cnt_a)
  );

  // Instance B: LSB first
  logic        en_b = 1'b0, rdy_b = 1'b1;
  logic        rd_b, bit_b, val_b, ws_b, busy_b, empty_b;
  logic [15:0] cnt_b;
  logic [7:0]  data_b = '0;
  logic [7:0]  mem_b [64];
  int          wp_b = 0, rp_b = 0;

  assign empty_b = (wp_b == rp_b);
  always @(posedge clk) if (rd_b) begin
    data_b <= mem_b[rp_b % 64];
    rp_b   <= rp_b + 1;
  end

  fifo_drain_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_i(en_b), .empty_i(empty_b), .rd_en_o(rd_b),
    .fifo_data_i(data_b), .bit_o(bit_b), .bit_valid_o(val_b), .bit_ready_i(rdy_b),
    .word_start_o(ws_b), .busy_o(busy_b), .word_cnt_o(cnt_b)
  );

  // Scoreboard for A: expected bits queued when a word enters the FIFO
  typedef struct packed {logic b; logic ws;} exp_t;
  exp_t exp_a[$];

  task automatic push_a(input logic [7:0] w);
    exp_t e;
    mem_a[wp_a % 64] = w;
    wp_a++;
    for (int i = 0; i < 8; i++) begin
      e.b  = w[7-i];
      e.ws = (i == 0);
      exp_a.push_back(e);
    end
  endtask

  int   cyc = 0, rd_pulses_a = 0, mon_idx = 0, last_end = 0, gap = 0, first_cyc = 0, ws_samples = 0;
  logic prev_stall = 1'b0, prev_bit = 1'b0, prev_ws = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      // A word cut by reset is never re-read: drop its remaining bits
      while (exp_a.size() > 0 && !exp_a[0].ws) e = exp_a.pop_front();
      mon_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (rd_a) rd_pulses_a++;
      if (ws_a) ws_samples++;
      if (prev_stall) begin
        chk("hold_valid", val_a, 1);
        chk("hold_bit", bit_a, prev_bit);
        chk("hold_word_start", ws_a, prev_ws);
      end
      if (val_a && rdy_a) begin
        chk("sb_bit_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          chk("sb_bit", bit_a, e.b);
          chk("sb_word_start", ws_a, e.ws);
        end
        if (ws_a) begin
          gap       = cyc - last_end;
          first_cyc = cyc;
        end
        if (mon_idx == 7) begin
          mon_idx  = 0;
          last_end = cyc;
        end else begin
          mon_idx++;
        end
      end
      prev_stall = val_a && !rdy_a;
      prev_bit   = bit_a;
      prev_ws    = ws_a;
    end
  end

  task automatic wait_done_a(input int max);
    int n = 0;
    while ((exp_a.size() != 0 || busy_a) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_budget", (exp_a.size() == 0) && !busy_a, 1);
  endtask

  typedef struct {
    logic [7:0]  word;
    int          stall_idx;
    int          stall_len;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          r0, c0, vseen, nbits, rdb;
    logic [15:0] cbase;
    logic [7:0]  w, got;
    logic        found;

    vecs[0] = '{8'h3C, 4, 3, 16'd2};
    vecs[1] = '{8'h5A, -1, 0, 16'd3};
    vecs[2] = '{8'h80, 0, 2, 16'd4};
    vecs[3] = '{8'h01, 7, 1, 16'd5};

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_rd_en", rd_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_bit", bit_a, 0);
    chk("rst_word_start", ws_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_word_cnt", cnt_a, 0);
    chk("rst_busy_b", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en_a  = 1'b1;
    repeat (2) @(negedge clk);

    // Single word 0xA5, first bit three cycles after empty drops
    r0 = rd_pulses_a;
    vseen = ws_samples;
    push_a(8'hA5);
    #3;
    c0 = cyc;
    wait_done_a(100);
    chk("t1_latency", first_cyc - c0, 3);
    chk("t1_rd_pulses", rd_pulses_a - r0, 1);
    chk("t1_word_start_once", ws_samples - vseen, 1);
    chk("t1_word_cnt", cnt_a, 1);

    // Table: words with optional back-pressure at a chosen bit index
    for (int i = 0; i < 4; i++) begin
      w  = vecs[i].word;
      @(negedge clk);
      r0 = rd_pulses_a;
      push_a(w);
      if (vecs[i].stall_idx >= 0) begin
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
          @(negedge clk);
          if (val_a && mon_idx == vecs[i].stall_idx) found = 1'b1;
        end
        chk("vec_stall_reached", found, 1);
        if (found) begin
          rdy_a = 1'b0;
          for (int s = 0; s < vecs[i].stall_len; s++) begin
            #3;
            chk("vec_stall_valid", val_a, 1);
            chk("vec_stall_bit", bit_a, w[7 - vecs[i].stall_idx]);
            @(negedge clk);
          end
          rdy_a = 1'b1;
        end
      end
      wait_done_a(100);
      chk("vec_word_cnt", cnt_a, vecs[i].exp_cnt);
      chk("vec_rd_pulses", rd_pulses_a - r0, 1);
    end

    // Empty FIFO with enable high: nothing moves
    @(negedge clk);
    r0 = rd_pulses_a;
    vseen = 0;
    repeat (50) begin
      @(negedge clk);
      #3;
      if (val_a) vseen++;
    end
    chk("t2_no_rd", rd_pulses_a - r0, 0);
    chk("t2_no_valid", vseen, 0);

    // Back-to-back words: two reads, REQ+WAIT bubble
    @(negedge clk);
    r0 = rd_pulses_a;
    cbase = cnt_a;
    push_a(8'hFF);
    push_a(8'h00);
    wait_done_a(100);
    chk("t4_rd_pulses", rd_pulses_a - r0, 2);
    chk("t4_word_cnt", cnt_a, cbase + 16'd2);
    chk("t4_bubble_gap", gap, 3);

    // Reset mid-word at bit index 5, then a fresh word
    @(negedge clk);
    push_a(8'h55);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (val_a && mon_idx == 5) found = 1'b1;
    end
    chk("t5_idx5_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", val_a, 0);
    chk("t5_rst_bit", bit_a, 0);
    chk("t5_rst_word_start", ws_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_rd_en", rd_a, 0);
    chk("t5_rst_word_cnt", cnt_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rd_pulses_a;
    push_a(8'h81);
    wait_done_a(100);
    chk("t5_rd_pulses", rd_pulses_a - r0, 1);
    chk("t5_word_cnt", cnt_a, 1);

    // LSB first, enable dropped at index 2 with more data waiting
    @(negedge clk);
    mem_b[wp_b % 64] = 8'h01;
    wp_b++;
    mem_b[wp_b % 64] = 8'h02;
    wp_b++;
    en_b  = 1'b1;
    nbits = 0;
    rdb   = 0;
    got   = '0;
    for (int n = 0; n < 60 && nbits < 8; n++) begin
      @(negedge clk);
      if (nbits >= 2) en_b = 1'b0;
      #3;
      if (rd_b) rdb++;
      if (val_b && rdy_b) begin
        chk("t6_word_start", ws_b, (nbits == 0));
        got[nbits] = bit_b;
        nbits++;
      end
    end
    chk("t6_bits_received", nbits, 8);
    chk("t6_word", got, 8'h01);
    repeat (20) begin
      @(negedge clk);
      #3;
      if (rd_b) rdb++;
    end
    chk("t6_rd_pulses", rdb, 1);
    chk("t6_word_cnt", cnt_b, 1);
    chk("t6_idle", busy_b, 0);
    chk("t6_fifo_left", empty_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
